// File: rtl/pong_pkg.sv
// Shared encodings and constants for the Pong game sequencer and its
// neighbouring datapath blocks.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SERVE = 2'b01,
      ST_PLAY  = 2'b10,
      ST_OVER  = 2'b11
   } game_state_e;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   localparam logic [1:0] TONE_NONE  = 2'b00;
   localparam logic [1:0] TONE_PAD   = 2'b01;
   localparam logic [1:0] TONE_WALL  = 2'b10;
   localparam logic [1:0] TONE_POINT = 2'b11;

   localparam logic [9:0] TICK_ROW = 10'd481;
   localparam logic [9:0] TICK_COL = 10'd0;

   // One cycle per frame, just below the visible area.
   function automatic logic is_frame_tick(input logic [9:0] col, input logic [9:0] row);
      return (row == TICK_ROW) && (col == TICK_COL);
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the game sequencer (slave) and the surrounding
// VGA/ball/button logic (master).
interface pong_game_ctrl_if;
   logic       start;
   logic [9:0] x;
   logic [9:0] y;
   logic       score1;
   logic       score2;
   logic       pad_hit;
   logic       wall_hit;
   logic [1:0] state;
   logic       ball_rst;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] winner;
   logic       tone_en;
   logic [1:0] tone_sel;

   modport master (
      output start, x, y, score1, score2, pad_hit, wall_hit,
      input  state, ball_rst, p1_score, p2_score, winner, tone_en, tone_sel
   );

   modport slave (
      input  start, x, y, score1, score2, pad_hit, wall_hit,
      output state, ball_rst, p1_score, p2_score, winner, tone_en, tone_sel
   );
endinterface

// File: rtl/pong_game_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; pulse is high
// for one clk cycle per rising edge of the asynchronous input.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic pulse
);
   logic sync1_r;
   logic sync2_r;
   logic prev_r;

   // Metastability chain plus one-cycle history for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= d;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign pulse = sync2_r & ~prev_r;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: IDLE/SERVE/PLAY/OVER, scoring, serve timing, winner.
// Optional sound cues are built only when PONG_SOUND_EN is defined.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 120,
   parameter int TONE_FRAMES  = 6
) (
   input logic             clk,
   input logic             reset,
   pong_game_ctrl_if.slave game
);
   localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
   localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

   logic        start_pulse_s;
   logic        frame_tick_s;
   logic        pt1_s;
   logic        pt2_s;
   logic        score1_r;
   logic        score1_d_r;
   logic        score2_r;
   logic        score2_d_r;
   game_state_e state_r;
   game_state_e state_nxt_s;
   logic [3:0]  p1_r;
   logic [3:0]  p2_r;
   logic [3:0]  p1_nxt_s;
   logic [3:0]  p2_nxt_s;
   logic [3:0]  p1_inc_s;
   logic [3:0]  p2_inc_s;
   logic [1:0]  winner_r;
   logic [1:0]  winner_nxt_s;
   logic [7:0]  serve_cnt_r;
   logic [7:0]  serve_cnt_nxt_s;
   logic        ball_rst_r;
   logic        ball_rst_nxt_s;

   sync_edge u_start_edge (
      .clk   (clk),
      .reset (reset),
      .d     (game.start),
      .pulse (start_pulse_s)
   );

   assign frame_tick_s = is_frame_tick(game.x, game.y);
   assign pt1_s        = score1_r & ~score1_d_r;
   assign pt2_s        = score2_r & ~score2_d_r;
   assign p1_inc_s     = p1_r + 4'd1;
   assign p2_inc_s     = p2_r + 4'd1;

   // Point flags stay high for a frame; only their rising edge scores
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score1_r   <= 1'b0;
         score1_d_r <= 1'b0;
         score2_r   <= 1'b0;
         score2_d_r <= 1'b0;
      end else begin
         score1_r   <= game.score1;
         score1_d_r <= score1_r;
         score2_r   <= game.score2;
         score2_d_r <= score2_r;
      end
   end

   // Game state, scoreboard and serve timer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         p1_r        <= 4'd0;
         p2_r        <= 4'd0;
         winner_r    <= WIN_NONE;
         serve_cnt_r <= 8'd0;
         ball_rst_r  <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         p1_r        <= p1_nxt_s;
         p2_r        <= p2_nxt_s;
         winner_r    <= winner_nxt_s;
         serve_cnt_r <= serve_cnt_nxt_s;
         ball_rst_r  <= ball_rst_nxt_s;
      end
   end

   // Next-state and scoreboard update
   always_comb begin
      state_nxt_s     = state_r;
      p1_nxt_s        = p1_r;
      p2_nxt_s        = p2_r;
      winner_nxt_s    = winner_r;
      serve_cnt_nxt_s = serve_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (start_pulse_s) begin
               state_nxt_s     = ST_SERVE;
               p1_nxt_s        = 4'd0;
               p2_nxt_s        = 4'd0;
               winner_nxt_s    = WIN_NONE;
               serve_cnt_nxt_s = 8'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SERVE: begin
            if (frame_tick_s) begin
               serve_cnt_nxt_s = serve_cnt_r + 8'd1;
               if (serve_cnt_r == SERVE_LAST) begin
                  state_nxt_s = ST_PLAY;
               end else begin
                  state_nxt_s = ST_SERVE;
               end
            end else begin
               state_nxt_s = ST_SERVE;
            end
         end
         ST_PLAY: begin
            // Player 1 wins a tie: pt2 in the same cycle is dropped
            if (pt1_s) begin
               p1_nxt_s = p1_inc_s;
               if (p1_inc_s == WIN_VAL) begin
                  winner_nxt_s = WIN_P1;
                  state_nxt_s  = ST_OVER;
               end else begin
                  serve_cnt_nxt_s = 8'd0;
                  state_nxt_s     = ST_SERVE;
               end
            end else if (pt2_s) begin
               p2_nxt_s = p2_inc_s;
               if (p2_inc_s == WIN_VAL) begin
                  winner_nxt_s = WIN_P2;
                  state_nxt_s  = ST_OVER;
               end else begin
                  serve_cnt_nxt_s = 8'd0;
                  state_nxt_s     = ST_SERVE;
               end
            end else begin
               state_nxt_s = ST_PLAY;
            end
         end
         ST_OVER: begin
            if (start_pulse_s) begin
               winner_nxt_s = WIN_NONE;
               state_nxt_s  = ST_IDLE;
            end else begin
               state_nxt_s = ST_OVER;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Ball is released only while the rally is live
   always_comb begin
      ball_rst_nxt_s = 1'b1;
      if (state_nxt_s == ST_PLAY) begin
         ball_rst_nxt_s = 1'b0;
      end else begin
         ball_rst_nxt_s = 1'b1;
      end
   end

   assign game.state    = state_r;
   assign game.ball_rst = ball_rst_r;
   assign game.p1_score = p1_r;
   assign game.p2_score = p2_r;
   assign game.winner   = winner_r;

`ifdef PONG_SOUND_EN
   localparam logic [7:0] TONE_LOAD = 8'(TONE_FRAMES);

   logic       play_s;
   logic [7:0] tone_cnt_r;
   logic [7:0] tone_cnt_nxt_s;
   logic [1:0] tone_sel_r;
   logic [1:0] tone_sel_nxt_s;
   logic       tone_en_r;

   assign play_s = (state_r == ST_PLAY);

   // Event load (point > paddle > wall), otherwise count down per frame
   always_comb begin
      tone_cnt_nxt_s = tone_cnt_r;
      tone_sel_nxt_s = tone_sel_r;
      if (play_s && (pt1_s || pt2_s)) begin
         tone_cnt_nxt_s = TONE_LOAD;
         tone_sel_nxt_s = TONE_POINT;
      end else if (play_s && game.pad_hit) begin
         tone_cnt_nxt_s = TONE_LOAD;
         tone_sel_nxt_s = TONE_PAD;
      end else if (play_s && game.wall_hit) begin
         tone_cnt_nxt_s = TONE_LOAD;
         tone_sel_nxt_s = TONE_WALL;
      end else if (frame_tick_s && (tone_cnt_r != 8'd0)) begin
         tone_cnt_nxt_s = tone_cnt_r - 8'd1;
         if (tone_cnt_r == 8'd1) begin
            tone_sel_nxt_s = TONE_NONE;
         end else begin
            tone_sel_nxt_s = tone_sel_r;
         end
      end else begin
         tone_cnt_nxt_s = tone_cnt_r;
      end
   end

   // Tone counter and registered cue outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tone_cnt_r <= 8'd0;
         tone_sel_r <= TONE_NONE;
         tone_en_r  <= 1'b0;
      end else begin
         tone_cnt_r <= tone_cnt_nxt_s;
         tone_sel_r <= tone_sel_nxt_s;
         tone_en_r  <= (tone_cnt_nxt_s != 8'd0);
      end
   end

   assign game.tone_en  = tone_en_r;
   assign game.tone_sel = tone_sel_r;
`else
   logic unused_tone_s;

   assign unused_tone_s = ^{8'(TONE_FRAMES), game.pad_hit, game.wall_hit};
   assign game.tone_en  = 1'b0;
   assign game.tone_sel = TONE_NONE;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized scoreboard bench for pong_game_ctrl against an event-level game model.
module tb_pong_game_ctrl;
   import pong_pkg::*;

   localparam int WIN = 5;
   localparam int SF  = 4;
   localparam int TF  = 6;
   localparam int M_IDLE  = 0;
   localparam int M_SERVE = 1;
   localparam int M_PLAY  = 2;
   localparam int M_OVER  = 3;

   typedef struct packed {
      logic [1:0] st;
      logic       br;
      logic [3:0] p1;
      logic [3:0] p2;
      logic [1:0] w;
   } snap_t;

   localparam snap_t RESET_SNAP = {2'b00, 1'b1, 4'd0, 4'd0, 2'b00};

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pong_game_ctrl_if game ();

   pong_game_ctrl #(
      .WIN_SCORE    (WIN),
      .SERVE_FRAMES (SF),
      .TONE_FRAMES  (TF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .game  (game)
   );

   snap_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   // game model: whole-game rules, one step per stimulus event
   int m_st = M_IDLE;
   int m_p1 = 0;
   int m_p2 = 0;
   int m_w  = 0;
   int m_cnt = 0;

   function automatic snap_t model_snap();
      snap_t s;
      s.st = 2'(m_st);
      s.br = (m_st != M_PLAY);
      s.p1 = 4'(m_p1);
      s.p2 = 4'(m_p2);
      s.w  = 2'(m_w);
      return s;
   endfunction

   task automatic push_exp();
      exp_q.push_back(model_snap());
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         game.x        = 10'($urandom_range(1, 799));
         game.y        = 10'($urandom_range(0, 524));
         game.pad_hit  = 1'b0;
         game.wall_hit = 1'b0;
      end
   endtask

   task automatic act_frames(input int n);
      for (int i = 0; i < n; i++) begin
         if (m_st == M_SERVE) begin
            m_cnt++;
            if (m_cnt == SF) begin
               m_st = M_PLAY;
               push_exp();
            end
         end
         @(posedge clk);
         #1;
         game.x = 10'd0;
         game.y = 10'd481;
         idle(1);
      end
   endtask

   task automatic act_start(input int hold);
      if (m_st == M_IDLE) begin
         m_st = M_SERVE; m_p1 = 0; m_p2 = 0; m_w = 0; m_cnt = 0;
         push_exp();
      end else if (m_st == M_OVER) begin
         m_st = M_IDLE; m_w = 0;
         push_exp();
      end
      @(posedge clk);
      #1;
      game.start = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      game.start = 1'b0;
      idle(4);
   endtask

   task automatic score_model(input logic a, input logic b);
      if (m_st == M_PLAY && (a || b)) begin
         if (a) m_p1++;
         else   m_p2++;
         if (m_p1 == WIN) begin
            m_w = 1; m_st = M_OVER;
         end else if (m_p2 == WIN) begin
            m_w = 2; m_st = M_OVER;
         end else begin
            m_st = M_SERVE; m_cnt = 0;
         end
         push_exp();
      end
   endtask

   task automatic act_point(input logic a, input logic b, input int hold);
      score_model(a, b);
      @(posedge clk);
      #1;
      game.score1 = a;
      game.score2 = b;
      repeat (hold) @(posedge clk);
      #1;
      game.score1 = 1'b0;
      game.score2 = 1'b0;
      idle(4);
   endtask

   task automatic act_hits();
      @(posedge clk);
      #1;
      game.pad_hit  = 1'($urandom_range(0, 1));
      game.wall_hit = 1'($urandom_range(0, 1));
      idle(2);
   endtask

   // Monitor: every output change must match the next queued expectation
   initial begin : monitor
      snap_t prev_v;
      snap_t cur_v;
      snap_t exp_v;
      prev_v = RESET_SNAP;
      forever begin
         @(negedge clk);
         cur_v = {game.state, game.ball_rst, game.p1_score, game.p2_score, game.winner};
         if (cur_v != prev_v) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change got=%h prev=%h at %0t", cur_v, prev_v, $time);
            end else begin
               exp_v = exp_q.pop_front();
               if (cur_v !== exp_v) begin
                  bad++;
                  $display("FAIL transition got=%h want=%h at %0t", cur_v, exp_v, $time);
               end
            end
            prev_v = cur_v;
         end
`ifndef PONG_SOUND_EN
         check("tone_off", {29'd0, game.tone_en, game.tone_sel}, 32'd0);
`endif
      end
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int kind;
      game.start    = 1'b0;
      game.x        = 10'd100;
      game.y        = 10'd100;
      game.score1   = 1'b0;
      game.score2   = 1'b0;
      game.pad_hit  = 1'b0;
      game.wall_hit = 1'b0;
      #1 reset = 1'b1;
      #20;
      check("rst_state", game.state, 32'd0);
      check("rst_ball", game.ball_rst, 32'd1);
      check("rst_scores", {game.p1_score, game.p2_score, game.winner}, 32'd0);
      check("rst_tone", {game.tone_en, game.tone_sel}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

      // start latency: SERVE appears on the third edge, not the second
      m_st = M_SERVE; m_cnt = 0;
      push_exp();
      @(posedge clk);
      #1 game.start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("start_lat_early", game.state, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("start_lat_serve", game.state, 32'd1);
      check("serve_ball_rst", game.ball_rst, 32'd1);
      game.start = 1'b0;
      idle(4);

      act_frames(SF - 1);
      @(negedge clk);
      check("serve_not_done", game.state, 32'd1);
      act_frames(1);
      @(negedge clk);
      check("play_state", game.state, 32'd2);
      check("play_ball_rst", game.ball_rst, 32'd0);

      // score latency: two edges from flag to output
      score_model(1'b1, 1'b0);
      @(posedge clk);
      #1 game.score1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("pt_lat_early", {game.state, game.p1_score}, {26'd0, 2'b10, 4'd0});
      @(posedge clk);
      @(negedge clk);
      check("pt_lat_done", {game.state, game.p1_score}, {26'd0, 2'b01, 4'd1});
      idle(20);
      game.score1 = 1'b0;
      idle(4);
      check("pt_once", game.p1_score, 32'd1);

      act_point(1'b1, 1'b0, 3);
      check("pt_in_serve", {game.state, game.p1_score}, {26'd0, 2'b01, 4'd1});
      act_frames(SF);
      act_start(3);
      check("start_in_play", game.state, 32'd2);
      act_point(1'b1, 1'b1, 2);
      check("tie_p1", {game.p1_score, game.p2_score}, {24'd0, 4'd2, 4'd0});
      for (int i = 0; i < 4; i++) begin
         act_frames(SF);
         act_point(1'b0, 1'b1, 1 + i);
      end
      act_frames(SF);
      @(negedge clk);
      check("pre_reset", {game.state, game.p1_score, game.p2_score}, {22'd0, 2'b10, 4'd2, 4'd4});

`ifdef PONG_SOUND_EN
      @(posedge clk);
      #1 game.pad_hit = 1'b1;
      @(posedge clk);
      #1 game.pad_hit = 1'b0;
      @(negedge clk);
      check("tone_pad_on", {game.tone_en, game.tone_sel}, {29'd0, 1'b1, 2'b01});
      for (int k = 1; k <= TF; k++) begin
         act_frames(1);
         @(negedge clk);
         check("tone_count", game.tone_en, (k < TF) ? 32'd1 : 32'd0);
      end
`endif

      // asynchronous reset in the middle of a clock period
      m_st = M_IDLE; m_p1 = 0; m_p2 = 0; m_w = 0; m_cnt = 0;
      push_exp();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_state", {game.state, game.ball_rst}, {29'd0, 2'b00, 1'b1});
      check("async_rst_vals", {game.p1_score, game.p2_score, game.winner, game.tone_en, game.tone_sel},
            32'd0);
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

      for (int n = 0; n < 250; n++) begin
         kind = $urandom_range(0, 99);
         if (kind < 15) begin
            act_start($urandom_range(1, 6));
         end else if (kind < 50) begin
            act_frames($urandom_range(1, SF + 1));
         end else if (kind < 85) begin
            case ($urandom_range(0, 2))
               0:       act_point(1'b1, 1'b0, $urandom_range(1, 20));
               1:       act_point(1'b0, 1'b1, $urandom_range(1, 20));
               default: act_point(1'b1, 1'b1, $urandom_range(1, 20));
            endcase
         end else if (kind < 95) begin
            act_hits();
         end else begin
            idle($urandom_range(1, 8));
         end
      end

      idle(10);
      check("queue_drained", exp_q.size(), 32'd0);
      check("final_model", {game.state, game.p1_score, game.p2_score, game.winner},
            {20'd0, model_snap().st, model_snap().p1, model_snap().p2, model_snap().w});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
